mmio_store: RTL

Store-side memory-mapped I/O sink placed directly downstream of the single-cycle core's data-memory port. It watches the core's `mem_we`/`mem_addr`/`mem_data` outputs every cycle and decodes stores into an LED register and a UART transmit path. The UART path is an 8-deep byte FIFO drained by an 8N1 serialiser. The core has no stall input, so this block never back-pressures: excess bytes are dropped and flagged.

---
 rtl/mmio_pkg.sv | 15 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/mmio_store.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared address map and serialiser state encoding for the store-side MMIO sink.
package mmio_pkg;

    localparam logic [31:0] MMIO_LED       = 32'h0000_1000;
    localparam logic [31:0] MMIO_UART_DATA = 32'h0000_1001;
    localparam logic [31:0] MMIO_OVF_CLR   = 32'h0000_1002;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read; push into a full FIFO succeeds only alongside a pop.
// Zero-cycle read latency; never stalls the writer, push_ok reports whether the entry was taken.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             push_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;

    // Extra MSB on each pointer separates full from empty when the low bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/mmio_store.sv
// Decodes core stores into an LED register and a FIFO-buffered 8N1 UART transmitter.
// LED updates at the store edge, UART line drops two edges later; never back-pressures, drops and flags instead.
module mmio_store
    import mmio_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_we,
    output logic [7:0]  leds,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        tx_overflow
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    uart_state_t  state;
    logic [7:0]   shreg;
    logic [2:0]   bit_idx;
    logic [CW-1:0] cnt;

    logic         led_we;
    logic         uart_we;
    logic         clr_we;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push_ok;
    logic [7:0]   fifo_dout;
    logic         unused_data;

    assign led_we      = mem_we && (mem_addr == MMIO_LED);
    assign uart_we     = mem_we && (mem_addr == MMIO_UART_DATA);
    assign clr_we      = mem_we && (mem_addr == MMIO_OVF_CLR);
    assign unused_data = ^mem_data[31:8];

    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
    assign tx_busy  = (state != ST_IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (uart_we),
        .push_data (mem_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_ok   (push_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds <= '0;
        end else if (led_we) begin
            leds <= mem_data[7:0];
        end
    end

    // A drop outranks a clear landing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_overflow <= 1'b0;
        end else if (uart_we && !push_ok) begin
            tx_overflow <= 1'b1;
        end else if (clr_we) begin
            tx_overflow <= 1'b0;
        end
    end

    // Line is registered from the current state, so it trails the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            cnt     <= BIT_LAST;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                ST_START: uart_tx <= 1'b0;
                ST_DATA:  uart_tx <= shreg[bit_idx];
                default:  uart_tx <= 1'b1;
            endcase

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shreg <= fifo_dout;
                        state <= ST_START;
                        cnt   <= BIT_LAST;
                    end
                end
                ST_START: begin
                    if (cnt == '0) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        cnt     <= BIT_LAST;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        cnt <= BIT_LAST;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        cnt   <= BIT_LAST;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
